// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: FSM encoding and depth helper.
package regfile_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   localparam int RAWIDTH_DFLT = 5;
   localparam int DEPTH        = 2 ** RAWIDTH_DFLT;

   function automatic int depth_of(input int aw);
      return 2 ** aw;
   endfunction

endpackage

// File: rtl/regfile_rd_mux.sv
// One read port: stored value, overridden by same-cycle write data (highest
// matching port wins), then forced to zero for register 0 and while clearing.
module regfile_rd_mux #(
   parameter int RAWIDTH  = 5,
   parameter int DWIDTH   = 32,
   parameter int NWR      = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                     run,
   input  logic [RAWIDTH-1:0]       raddr,
   input  logic [DWIDTH-1:0]        stored,
   input  logic [NWR-1:0]           wen,
   input  logic [NWR*RAWIDTH-1:0]   waddr,
   input  logic [NWR*DWIDTH-1:0]    wdata,
   output logic [DWIDTH-1:0]        rdata
);

   logic              byp_hit;
   logic [DWIDTH-1:0] byp_data;

   always_comb begin
      byp_hit  = 1'b0;
      byp_data = '0;
      // ascending scan so a later (higher-index) match overwrites an earlier one
      for (int w = 0; w < NWR; w++) begin
         if (wen[w] && (waddr[w*RAWIDTH +: RAWIDTH] == raddr)) begin
            byp_hit  = 1'b1;
            byp_data = wdata[w*DWIDTH +: DWIDTH];
         end
      end
   end

   always_comb begin
      rdata = stored;
      if ((BYPASS != 0) && byp_hit) rdata = byp_data;
      if ((ZERO_REG != 0) && (raddr == '0)) rdata = '0;
      if (!run) rdata = '0;
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port flop-based register file with a post-reset clear sweep.
//   state    | meaning
//   ST_CLEAR | sweeping entry[cnt] to zero, writes ignored, reads return 0
//   ST_RUN   | normal operation, ready high
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int RAWIDTH  = 5,
   parameter int DWIDTH   = 32,
   parameter int NRD      = 2,
   parameter int NWR      = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     ready,
   input  logic [NWR-1:0]           RegWEn,
   input  logic [NWR*RAWIDTH-1:0]   AddrD,
   input  logic [NWR*DWIDTH-1:0]    DataD,
   input  logic [NRD*RAWIDTH-1:0]   AddrR,
   output logic [NRD*DWIDTH-1:0]    DataR
);

   localparam int NENT = depth_of(RAWIDTH);

   state_t             state;
   state_t             state_nxt;
   logic [RAWIDTH-1:0] cnt;
   logic [RAWIDTH-1:0] cnt_nxt;
   logic               run;
   logic [DWIDTH-1:0]  mem [NENT];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_CLEAR: begin
            cnt_nxt = cnt + 1'b1;
            if (&cnt) state_nxt = ST_RUN;
         end
         ST_RUN:   state_nxt = ST_RUN;
         default:  state_nxt = ST_CLEAR;
      endcase
   end

   assign run   = (state == ST_RUN);
   assign ready = run;

   // later loop iterations override earlier ones, so the higher port wins a collision
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (!run) begin
            mem[cnt] <= '0;
         end else begin
            for (int w = 0; w < NWR; w++) begin
               if (RegWEn[w] &&
                   !((ZERO_REG != 0) && (AddrD[w*RAWIDTH +: RAWIDTH] == '0))) begin
                  mem[AddrD[w*RAWIDTH +: RAWIDTH]] <= DataD[w*DWIDTH +: DWIDTH];
               end
            end
         end
      end
   end

   for (genvar r = 0; r < NRD; r++) begin : g_rd
      logic [RAWIDTH-1:0] raddr;
      logic [DWIDTH-1:0]  stored;

      assign raddr  = AddrR[r*RAWIDTH +: RAWIDTH];
      assign stored = mem[raddr];

      regfile_rd_mux #(
         .RAWIDTH  (RAWIDTH),
         .DWIDTH   (DWIDTH),
         .NWR      (NWR),
         .BYPASS   (BYPASS),
         .ZERO_REG (ZERO_REG)
      ) u_rd_mux (
         .run    (run),
         .raddr  (raddr),
         .stored (stored),
         .wen    (RegWEn),
         .waddr  (AddrD),
         .wdata  (DataD),
         .rdata  (DataR[r*DWIDTH +: DWIDTH])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default build (2R/2W, bypass) and a 4R/1W no-bypass
// build, both checked against an array-based reference model.
`timescale 1ns/1ps
module tb_regfile_mp;

   logic clk;
   logic rst;

   logic         a_ready;
   logic [1:0]   a_wen;
   logic [9:0]   a_addrd;
   logic [63:0]  a_datad;
   logic [9:0]   a_addrr;
   logic [63:0]  a_datar;

   logic         b_ready;
   logic [0:0]   b_wen;
   logic [4:0]   b_addrd;
   logic [31:0]  b_datad;
   logic [19:0]  b_addrr;
   logic [127:0] b_datar;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 0;

   logic [31:0] ma [32];
   logic [31:0] mb [32];
   int          sweep_left = 32;

   regfile_mp u_dut_a (
      .clk(clk), .rst(rst), .ready(a_ready),
      .RegWEn(a_wen), .AddrD(a_addrd), .DataD(a_datad),
      .AddrR(a_addrr), .DataR(a_datar)
   );

   regfile_mp #(.NRD(4), .NWR(1), .BYPASS(0)) u_dut_b (
      .clk(clk), .rst(rst), .ready(b_ready),
      .RegWEn(b_wen), .AddrD(b_addrd), .DataD(b_datad),
      .AddrR(b_addrr), .DataR(b_datar)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   // Reference read value: zero while sweeping or for reg 0, else the
   // highest-index enabled writer to that address (bypass), else storage.
   function automatic logic [31:0] exp_a(input int r);
      logic [4:0] ad;
      ad = a_addrr[r*5 +: 5];
      if (sweep_left != 0 || ad == 5'd0) return 32'd0;
      for (int w = 1; w >= 0; w--)
         if (a_wen[w] && a_addrd[w*5 +: 5] == ad) return a_datad[w*32 +: 32];
      return ma[ad];
   endfunction

   function automatic logic [31:0] exp_b(input int r);
      logic [4:0] ad;
      ad = b_addrr[r*5 +: 5];
      if (sweep_left != 0 || ad == 5'd0) return 32'd0;
      return mb[ad];
   endfunction

   task automatic sample();
      @(negedge clk);
      if (chk_en) begin
         chk("a_ready", 32'(a_ready), 32'(sweep_left == 0));
         chk("b_ready", 32'(b_ready), 32'(sweep_left == 0));
         for (int r = 0; r < 2; r++) chk($sformatf("a_rd%0d", r), a_datar[r*32 +: 32], exp_a(r));
         for (int r = 0; r < 4; r++) chk($sformatf("b_rd%0d", r), b_datar[r*32 +: 32], exp_b(r));
      end
   endtask

   task automatic tick();
      logic [4:0] ad;
      @(posedge clk);
      if (rst) begin
         sweep_left = 32;
      end else if (sweep_left > 0) begin
         sweep_left--;
         if (sweep_left == 0) begin
            for (int i = 0; i < 32; i++) begin
               ma[i] = 32'd0;
               mb[i] = 32'd0;
            end
         end
      end else begin
         for (int w = 0; w < 2; w++) begin
            ad = a_addrd[w*5 +: 5];
            if (a_wen[w] && ad != 5'd0) ma[ad] = a_datad[w*32 +: 32];
         end
         if (b_wen[0] && b_addrd != 5'd0) mb[b_addrd] = b_datad;
      end
      #1;
   endtask

   task automatic idle();
      a_wen = '0; a_addrd = '0; a_datad = '0;
      b_wen = '0; b_addrd = '0; b_datad = '0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      a_addrr = '0;
      b_addrr = '0;

      // reset and sweep timing
      for (int i = 0; i < 3; i++) begin
         sample();
         tick();
         chk_en = 1;
      end
      rst = 1'b0;
      chk("rst_ready", 32'(a_ready), 32'd0);
      for (int e = 1; e <= 32; e++) begin
         tick();
         sample();
         chk("sweep_ready", 32'(a_ready), 32'(e == 32));
      end
      for (int i = 0; i < 32; i++) begin
         a_addrr = {5'(i), 5'(i)};
         sample();
         chk("clr_rd0", a_datar[31:0], 32'd0);
         chk("clr_rd1", a_datar[63:32], 32'd0);
         tick();
      end

      // basic write then read
      a_wen = 2'b01; a_addrd = {5'd0, 5'd5}; a_datad = {32'd0, 32'hDEADBEEF};
      sample(); tick();
      idle();
      a_addrr = {5'd6, 5'd5};
      sample();
      chk("basic_rd0", a_datar[31:0], 32'hDEADBEEF);
      chk("basic_rd1", a_datar[63:32], 32'd0);
      tick();

      // collision: higher port wins, also on the bypass path
      a_wen = 2'b11; a_addrd = {5'd7, 5'd7}; a_datad = {32'h22222222, 32'h11111111};
      a_addrr = {5'd7, 5'd7};
      sample();
      chk("coll_byp", a_datar[31:0], 32'h22222222);
      tick();
      idle();
      sample();
      chk("coll_store", a_datar[63:32], 32'h22222222);
      tick();

      // register 0 stays zero
      a_wen = 2'b01; a_addrd = {5'd0, 5'd0}; a_datad = {32'd0, 32'hFFFFFFFF};
      a_addrr = {5'd0, 5'd0};
      sample();
      chk("zero_same", a_datar[31:0], 32'd0);
      tick();
      idle();
      sample();
      chk("zero_next", a_datar[63:32], 32'd0);
      tick();

      // bypass versus no bypass
      a_wen = 2'b10; a_addrd = {5'd9, 5'd0}; a_datad = {32'hCAFEF00D, 32'd0};
      b_wen = 1'b1;  b_addrd = 5'd9;         b_datad = 32'hCAFEF00D;
      a_addrr = {5'd0, 5'd9};
      b_addrr = {15'd0, 5'd9};
      sample();
      chk("byp_a_same", a_datar[31:0], 32'hCAFEF00D);
      chk("nobyp_b_same", b_datar[31:0], 32'd0);
      tick();
      idle();
      sample();
      chk("byp_a_next", a_datar[31:0], 32'hCAFEF00D);
      chk("nobyp_b_next", b_datar[31:0], 32'hCAFEF00D);
      tick();

      // fill, then reset in the middle of a sweep
      for (int i = 1; i < 32; i++) begin
         a_wen = 2'b01; a_addrd = {5'd0, 5'(i)}; a_datad = {32'd0, 32'(i)};
         b_wen = 1'b1;  b_addrd = 5'(i);        b_datad = 32'(i);
         sample(); tick();
      end
      idle();
      a_addrr = {5'd5, 5'd3};
      b_addrr = {15'd0, 5'd3};
      sample();
      chk("fill_rd3", a_datar[31:0], 32'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sample(); tick();
      end
      rst = 1'b1;
      a_wen = 2'b01; a_addrd = {5'd0, 5'd3}; a_datad = {32'd0, 32'h0000AAAA};
      b_wen = 1'b1;  b_addrd = 5'd3;         b_datad = 32'h0000AAAA;
      sample(); tick();
      rst = 1'b0;
      for (int e = 1; e <= 32; e++) begin
         tick();
         sample();
         chk("resweep_ready", 32'(a_ready), 32'(e == 32));
         if (e < 32) chk("clear_masked", a_datar[31:0], 32'd0);
      end
      idle();
      tick();
      sample();
      chk("drop_a3", a_datar[31:0], 32'd0);
      chk("drop_a5", a_datar[63:32], 32'd0);
      chk("drop_b3", b_datar[31:0], 32'd0);
      tick();

      // random traffic against the model
      for (int c = 0; c < 10000; c++) begin
         rst     = ($urandom_range(0, 1999) == 0);
         a_wen   = 2'($urandom);
         a_addrd = 10'($urandom);
         a_datad = {$urandom, $urandom};
         a_addrr = 10'($urandom);
         if ($urandom_range(0, 3) == 0) a_addrr[4:0] = a_addrd[9:5];
         b_wen   = 1'($urandom);
         b_addrd = 5'($urandom);
         b_datad = $urandom;
         b_addrr = 20'($urandom);
         if ($urandom_range(0, 3) == 0) b_addrr[9:5] = b_addrd;
         sample();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Multi-port, parametrised integer register file for the next-generation core. Successor to the single-write/dual-read register file.
- Adds configurable read and write port counts, optional write-to-read bypass and a hardware clear sweep after reset.
- Sits between the decode stage (read addresses) and the writeback stage(s) (write ports).
- Register 0 is optionally hard-wired to zero.

Parameters:
- RAWIDTH, 5, register address width; depth = 2**RAWIDTH entries.
- DWIDTH, 32, data width of each entry.
- NRD, 2, number of read ports (1..4).
- NWR, 2, number of write ports (1..2).
- BYPASS, 1, 1 = a read returns same-cycle write data; 0 = a read returns stored contents only.
- ZERO_REG, 1, 1 = entry 0 always reads zero and ignores writes.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  high when the clear sweep is complete and writes are accepted.
- RegWEn  in  NWR  per-port write enable.
- AddrD  in  NWR*RAWIDTH  write addresses; port w occupies bits [w*RAWIDTH +: RAWIDTH].
- DataD  in  NWR*DWIDTH  write data, packed the same way.
- AddrR  in  NRD*RAWIDTH  read addresses, packed.
- DataR  out  NRD*DWIDTH  read data, packed; combinational.

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst, sampled at the rising edge of clk.
- FSM states: CLEAR, RUN.
- Reset:
  - rst=1 at an edge forces CLEAR, clear counter <= 0, ready <= 0.
  - rst has priority over everything, including mid-sweep; the sweep then restarts from entry 0.
- CLEAR:
  - Each cycle, entry[cnt] <= 0 and cnt <= cnt+1.
  - When cnt == 2**RAWIDTH-1 that entry is cleared and the FSM moves to RUN, with ready <= 1 on the same edge.
  - Sweep therefore takes exactly 2**RAWIDTH cycles after rst deasserts (32 at defaults). ready rises on the 32nd edge after the first edge with rst=0.
  - During CLEAR, RegWEn is ignored and every DataR reads 0. Bypass is inactive.
- RUN, writes:
  - Port w writes entry[AddrD_w] <= DataD_w when RegWEn[w]=1.
  - With ZERO_REG=1, a write to address 0 is discarded.
- Write collision:
  - Two enabled ports with the same address: the higher-index port wins. The lower port's data is lost silently.
- RUN, reads:
  - DataR_r = entry[AddrR_r], combinational, zero latency.
  - With ZERO_REG=1, address 0 always returns 0, including under bypass.
- Bypass (BYPASS=1, RUN only):
  - If any enabled write port matches AddrR_r this cycle, DataR_r = DataD of the highest-index matching port. Otherwise it returns the stored value.
  - With BYPASS=0, a same-cycle read returns the old value; the new value is visible from the next cycle.
- Width rules: addresses are unsigned; all 2**RAWIDTH entries are addressable; no out-of-range case exists.
- Storage: flops (no SRAM inference), so the clear sweep and multi-write both work.

Decomposition:
- Shared package regfile_pkg holds:
  - State encoding constants ST_CLEAR=1'b0, ST_RUN=1'b1.
  - Helper localparam DEPTH = 2**RAWIDTH.
- One natural sub-module: regfile_rd_mux. It implements a single read port: bypass compare across the write ports with highest-index priority, zero-register override and CLEAR masking. It is instantiated NRD times in a generate loop.

Test Plan:
- Reset sweep: assert rst 3 cycles, release. Required: ready=0 for 31 edges and 1 on the 32nd; all 32 entries then read 0 on both read ports.
- Basic write/read: write port0 addr 5 = 0xDEADBEEF. Required: next cycle AddrR0=5 returns 0xDEADBEEF; AddrR1=6 returns 0.
- Collision and zero register:
  - Ports 0 and 1 both write addr 7 with 0x11111111 and 0x22222222. Required: entry 7 = 0x22222222.
  - Write addr 0 = 0xFFFFFFFF. Required: reads of addr 0 return 0, also in the same cycle.
- Bypass:
  - BYPASS=1: write port1 addr 9 = 0xCAFEF00D while AddrR0=9 in the same cycle. Required: DataR0 = 0xCAFEF00D in that cycle.
  - BYPASS=0 build: DataR0 shows the old value (0) that cycle and 0xCAFEF00D the next cycle.
- Reset mid-operation:
  - Fill entries 1..31 with their index. Then pulse rst during the sweep at cnt=10.
  - Required: the sweep restarts at entry 0, and ready rises 32 cycles after the final rst release.
  - Writes issued during CLEAR (addr 3 = 0xAAAA) are dropped: entry 3 reads 0 after ready.
- Multi-port config (NRD=4, NWR=1): random write/read traffic checked against a reference model for 10k cycles. Required: zero mismatches.
